// File: rtl/au_cell_seq_pkg.sv
// Shared encodings and defaults for the alignment-cell sequencer.
// The AU_CELL_SEQ_LOCAL_ALIGN_EN macro adds the ZERO state to the FSM.
package au_cell_seq_pkg;

    localparam logic [1:0] AU_SUB = 2'b00;
    localparam logic [1:0] AU_ADD = 2'b01;
    localparam logic [1:0] AU_MAX = 2'b10;

    localparam int MATCH_DEFAULT    = 2;
    localparam int MISMATCH_DEFAULT = -1;
    localparam int GAP_DEFAULT      = 1;

    typedef enum logic [2:0] {
        StIdle,
        StDiag,
        StUp,
        StMax1,
        StLeft,
        StMax2,
        StZero,
        StDone
    } state_e;

endpackage

// File: rtl/au_cell_seq_au2.sv
// Combinational signed arithmetic unit: subtract, add or signed max of two words.
module au_cell_seq_au2
    import au_cell_seq_pkg::*;
#(
    parameter int unsigned MSB = 15
) (
    output logic signed [MSB:0] Out,
    input  logic signed [MSB:0] In1,
    input  logic signed [MSB:0] In2,
    input  logic        [1:0]   ctrl
);

    always_comb begin
        unique case (ctrl)
            AU_SUB:  Out = In1 - In2;
            AU_ADD:  Out = In1 + In2;
            default: Out = (In1 > In2) ? In1 : In2;
        endcase
    end

endmodule

// File: rtl/au_cell_seq.sv
// Time-multiplexes one AU to compute H = max(diag + s, up - GAP, left - GAP).
// Define AU_CELL_SEQ_LOCAL_ALIGN_EN to clamp the result at zero (local alignment).
module au_cell_seq
    import au_cell_seq_pkg::*;
#(
    parameter int unsigned MSB      = 15,
    parameter int          MATCH    = MATCH_DEFAULT,
    parameter int          MISMATCH = MISMATCH_DEFAULT,
    parameter int          GAP      = GAP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [MSB:0] in_diag,
    input  logic signed [MSB:0] in_up,
    input  logic signed [MSB:0] in_left,
    input  logic              in_match,
    output logic              out_valid,
    input  logic              out_ready,
    output logic signed [MSB:0] out_h,
    output logic              busy
);

    localparam int W = int'(MSB) + 1;
    localparam logic signed [MSB:0] MatchW    = W'(MATCH);
    localparam logic signed [MSB:0] MismatchW = W'(MISMATCH);
    localparam logic signed [MSB:0] GapW      = W'(GAP);

    state_e state_q, state_d;
    logic signed [MSB:0] diag_q, diag_d;
    logic signed [MSB:0] up_q, up_d;
    logic signed [MSB:0] left_q, left_d;
    logic                match_q, match_d;
    logic signed [MSB:0] acc_q, acc_d;
    logic signed [MSB:0] tmp_q, tmp_d;

    logic signed [MSB:0] au_in1, au_in2, au_out;
    logic        [1:0]   au_ctrl;

    au_cell_seq_au2 #(
        .MSB (MSB)
    ) u_au2 (
        .Out  (au_out),
        .In1  (au_in1),
        .In2  (au_in2),
        .ctrl (au_ctrl)
    );

    always_comb begin
        state_d = state_q;
        diag_d  = diag_q;
        up_d    = up_q;
        left_d  = left_q;
        match_d = match_q;
        acc_d   = acc_q;
        tmp_d   = tmp_q;
        au_ctrl = AU_MAX;
        au_in1  = acc_q;
        au_in2  = tmp_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    diag_d  = in_diag;
                    up_d    = in_up;
                    left_d  = in_left;
                    match_d = in_match;
                    state_d = StDiag;
                end
            end
            StDiag: begin
                au_ctrl = AU_ADD;
                au_in1  = diag_q;
                au_in2  = match_q ? MatchW : MismatchW;
                acc_d   = au_out;
                state_d = StUp;
            end
            StUp: begin
                au_ctrl = AU_SUB;
                au_in1  = up_q;
                au_in2  = GapW;
                tmp_d   = au_out;
                state_d = StMax1;
            end
            StMax1: begin
                acc_d   = au_out;
                state_d = StLeft;
            end
            StLeft: begin
                au_ctrl = AU_SUB;
                au_in1  = left_q;
                au_in2  = GapW;
                tmp_d   = au_out;
                state_d = StMax2;
            end
            StMax2: begin
                acc_d   = au_out;
`ifdef AU_CELL_SEQ_LOCAL_ALIGN_EN
                state_d = StZero;
`else
                state_d = StDone;
`endif
            end
`ifdef AU_CELL_SEQ_LOCAL_ALIGN_EN
            StZero: begin
                au_in2  = '0;
                acc_d   = au_out;
                state_d = StDone;
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            diag_q  <= '0;
            up_q    <= '0;
            left_q  <= '0;
            match_q <= 1'b0;
            acc_q   <= '0;
            tmp_q   <= '0;
        end else begin
            state_q <= state_d;
            diag_q  <= diag_d;
            up_q    <= up_d;
            left_q  <= left_d;
            match_q <= match_d;
            acc_q   <= acc_d;
            tmp_q   <= tmp_d;
        end
    end

    // acc only changes in compute states, so out_h is stable while DONE stalls.
    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign out_h     = acc_q;

endmodule

// File: tb/tb_au_cell_seq.sv
// Randomized and directed bench for au_cell_seq against a cell-level score model.
module tb_au_cell_seq;

`ifdef AU_CELL_SEQ_LOCAL_ALIGN_EN
    localparam int LAT   = 7;
    localparam bit LOCAL = 1'b1;
`else
    localparam int LAT   = 6;
    localparam bit LOCAL = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_diag = '0;
    logic signed [15:0] in_up = '0;
    logic signed [15:0] in_left = '0;
    logic               in_match = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] out_h;
    logic               busy;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    // Cell-level model: busy flag, edges since acceptance, expected score.
    bit                 m_busy = 1'b0;
    int                 m_cnt = 0;
    logic signed [15:0] m_h = '0;

    always #5 clk = ~clk;

    au_cell_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_diag   (in_diag),
        .in_up     (in_up),
        .in_left   (in_left),
        .in_match  (in_match),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_h     (out_h),
        .busy      (busy)
    );

    function automatic logic signed [15:0] cell_score(input logic signed [15:0] d,
                                                      input logic signed [15:0] u,
                                                      input logic signed [15:0] l,
                                                      input bit m);
        logic signed [15:0] a, b, c, h;
        a = d + (m ? 16'sd2 : -16'sd1);
        b = u - 16'sd1;
        c = l - 16'sd1;
        h = a;
        if (b > h) h = b;
        if (c > h) h = c;
        if (LOCAL && h < 0) h = '0;
        return h;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                m_h    <= cell_score(in_diag, in_up, in_left, in_match);
            end
        end else if (m_cnt < LAT) begin
            m_cnt <= m_cnt + 1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ops(input int d, input int u, input int l, input bit m);
        in_diag  = 16'(d);
        in_up    = 16'(u);
        in_left  = 16'(l);
        in_match = m;
    endtask

    // Called and returns at a point between a posedge and the next posedge.
    task automatic run_cell(input string name, input int d, input int u, input int l,
                            input bit m, input int exp_h, input int stall,
                            input bit pre_next, input int nd, input int nu,
                            input int nl, input bit nm);
        int n;
        int lat;
        set_ops(d, u, l, m);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_accept_timeout"}, int'(in_ready), 1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        if (pre_next) set_ops(nd, nu, nl, nm);
        else in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({name, "_latency"}, lat, LAT);
        chk({name, "_out_h"}, int'(out_h), exp_h);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, "_stall_h"}, int'(out_h), exp_h);
            chk({name, "_stall_valid"}, int'(out_valid), 1);
            chk({name, "_stall_in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_ready_after_hs"}, int'(in_ready), 1);
        chk({name, "_valid_after_hs"}, int'(out_valid), 0);
    endtask

    initial begin
        fork
            begin : compare
                while (!done) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        chk("rst_in_ready", int'(in_ready), 1);
                        chk("rst_out_valid", int'(out_valid), 0);
                        chk("rst_busy", int'(busy), 0);
                        chk("rst_out_h", int'(out_h), 0);
                    end else begin
                        chk("in_ready", int'(in_ready), int'(!m_busy));
                        chk("busy", int'(busy), int'(m_busy));
                        chk("out_valid", int'(out_valid), int'(m_busy && m_cnt == LAT));
                        if (m_busy && m_cnt == LAT) chk("out_h", int'(out_h), int'(m_h));
                    end
                end
            end
            begin : stimulus
                #2;
                chk("init_out_h", int'(out_h), 0);
                chk("init_in_ready", int'(in_ready), 1);
                chk("init_out_valid", int'(out_valid), 0);
                chk("model_pin_wrap", int'(cell_score(16'sh7fff, -16'sd100, -16'sd100, 1'b1)),
                    LOCAL ? 0 : -101);
                chk("model_pin_neg", int'(cell_score(-16'sd5, -16'sd8, -16'sd3, 1'b1)),
                    LOCAL ? 0 : -3);
                @(negedge clk);
                @(negedge clk);
                #1 rst_n = 1'b1;

                run_cell("c1", 5, 3, 4, 1'b1, 7, 0, 1'b0, 0, 0, 0, 1'b0);
                run_cell("c2", 0, 10, 2, 1'b0, 9, 0, 1'b0, 0, 0, 0, 1'b0);
                run_cell("c3", -5, -8, -3, 1'b1, LOCAL ? 0 : -3, 0, 1'b0, 0, 0, 0, 1'b0);
                run_cell("stallA", 7, 0, 0, 1'b0, 6, 3, 1'b1, 1, 2, 3, 1'b1);
                run_cell("stallB", 1, 2, 3, 1'b1, 3, 0, 1'b0, 0, 0, 0, 1'b0);

                // Reset while the FSM is in MAX1.
                set_ops(20, 0, 0, 1'b1);
                in_valid  = 1'b1;
                out_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                in_valid = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("midrst_out_valid", int'(out_valid), 0);
                chk("midrst_in_ready", int'(in_ready), 1);
                chk("midrst_out_h", int'(out_h), 0);
                chk("midrst_busy", int'(busy), 0);
                @(negedge clk);
                #1 rst_n = 1'b1;
                run_cell("post_rst", 1, 1, 1, 1'b1, 3, 0, 1'b0, 0, 0, 0, 1'b0);
                run_cell("wrap", 32767, -100, -100, 1'b1, LOCAL ? 0 : -101, 0, 1'b0,
                         0, 0, 0, 1'b0);

                for (int i = 0; i < 600; i++) begin
                    @(negedge clk);
                    in_valid = ($urandom_range(0, 1) == 1);
                    if ($urandom_range(0, 3) == 0) begin
                        in_diag = 16'($urandom);
                        in_up   = 16'($urandom);
                        in_left = 16'($urandom);
                    end else begin
                        set_ops(int'($urandom_range(0, 100)) - 50,
                                int'($urandom_range(0, 100)) - 50,
                                int'($urandom_range(0, 100)) - 50, 1'b0);
                    end
                    in_match  = ($urandom_range(0, 1) == 1);
                    out_ready = ($urandom_range(0, 9) < 7);
                end
                @(negedge clk);
                in_valid  = 1'b0;
                out_ready = 1'b1;
                repeat (20) @(negedge clk);
                done = 1'b1;
            end
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
